// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared types for the data-memory request/response interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        WAIT = c_ST_WAIT,
        RESP = c_ST_RESP
    } dmem_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module      : dmem_array
// Description : Word-addressed storage, per-byte write enable, synchronous
//               read into a held output register. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 256,
    parameter int IDX_W      = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic                    re,
    input  logic [IDX_W-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] r_mem [WORDS];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (be[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        // Read data is held between reads so the response can stall freely.
        if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Slave side of the data-memory request/response interface with
//               a fixed, parameterised response latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int DMEM_SZ_IN_KB = 1,
    parameter int LATENCY       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    import dmem_responder_pkg::*;

    localparam int                    c_WORDS   = DMEM_SZ_IN_KB * 1024 / WORD_BYTES;
    localparam int                    c_IDX_W   = $clog2(c_WORDS);
    localparam logic [DATA_WIDTH-3:0] c_WORDS_V = (DATA_WIDTH-2)'(c_WORDS);
    localparam logic [3:0]            c_LAT_M1  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    dmem_state_t r_state;
    dmem_state_t w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_err;
    logic        r_load_ok;

    dmem_req_t             w_req;
    dmem_rsp_t             w_rsp;
    logic                  w_accept;
    logic                  w_err;
    logic                  w_arr_we;
    logic                  w_arr_re;
    logic [DATA_WIDTH-1:0] w_arr_rdata;

    assign w_req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_err    = (w_req.addr[1:0] != 2'b00) || (w_req.addr[DATA_WIDTH-1:2] >= c_WORDS_V);
    assign w_arr_we = w_accept &&  w_req.we && !w_err;
    assign w_arr_re = w_accept && !w_req.we && !w_err;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (c_WORDS),
        .IDX_W      (c_IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (w_arr_we),
        .re    (w_arr_re),
        .addr  (w_req.addr[c_IDX_W+1:2]),
        .wdata (w_req.wdata),
        .be    (w_req.be),
        .rdata (w_arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_err     <= 1'b0;
            r_load_ok <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt     <= c_LAT_M1;
                r_err     <= w_err;
                r_load_ok <= w_arr_re;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY > 0) w_state_nxt = WAIT;
                    else             w_state_nxt = RESP;
                end
            end
            WAIT:    if (r_cnt == 4'd0) w_state_nxt = RESP;
            RESP:    if (rsp_ready)     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Stores and errors report zero data; only a good load exposes the array word.
    always_comb begin
        w_rsp.rdata = r_load_ok ? w_arr_rdata : '0;
        w_rsp.err   = r_err;
        req_ready   = (r_state == IDLE);
        rsp_valid   = (r_state == RESP);
        rsp_rdata   = w_rsp.rdata;
        rsp_err     = w_rsp.err;
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder at LATENCY 2, 0 and 15.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    import dmem_responder_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int c_LAT [3] = '{2, 0, 15};

    logic        clk;
    logic        rst;
    logic        req_valid [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_ready [3];
    wire  [2:0]  req_ready;
    wire  [2:0]  rsp_valid;
    wire  [2:0]  rsp_err;
    wire  [31:0] rsp_rdata [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_t0  = 0;
    dmem_rsp_t sb_q [$];
    vec_t      vecs [$];

    dmem_responder #(.LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.LATENCY(15)) u_dut_l15 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Starts and ends just after a falling edge; a stall > 0 holds rsp_ready low
    // that many cycles and fires a stray store request meanwhile.
    task automatic xfer(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int stall, input string name);
        int        n;
        dmem_rsp_t e;
        sb_q.push_back('{rdata: exp_rdata, err: exp_err});
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        rsp_ready[d] = (stall == 0);
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk({name, "_accept_timeout"}, 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        last_t0      = cyc;
        req_valid[d] = 1'b0;
        n = 1;
        while (rsp_valid[d] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(c_LAT[d] + 1));
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_rdata"}, rsp_rdata[d], e.rdata);
            chk({name, "_err"}, 32'(rsp_err[d]), 32'(e.err));
            for (int i = 0; i < stall; i++) begin
                if (i == 3) begin
                    req_valid[d] = 1'b1;
                    req_we[d]    = 1'b1;
                    req_addr[d]  = 32'h10;
                    req_wdata[d] = 32'h0;
                    req_be[d]    = 4'hF;
                end
                if (i == 5) req_valid[d] = 1'b0;
                @(negedge clk);
                chk($sformatf("%s_stall%0d_valid", name, i), 32'(rsp_valid[d]), 32'd1);
                chk($sformatf("%s_stall%0d_ready", name, i), 32'(req_ready[d]), 32'd0);
                chk($sformatf("%s_stall%0d_rdata", name, i), rsp_rdata[d], e.rdata);
                chk($sformatf("%s_stall%0d_err", name, i), 32'(rsp_err[d]), 32'(e.err));
            end
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        chk({name, "_post_valid"}, 32'(rsp_valid[d]), 32'd0);
        chk({name, "_post_ready"}, 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_a;
        int n;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
            req_be[d]    = 4'h0;
            rsp_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset%0d_valid", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("reset%0d_ready", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("reset%0d_rdata", d), rsp_rdata[d], 32'd0);
            chk($sformatf("reset%0d_err", d), 32'(rsp_err[d]), 32'd0);
        end

        //                we     addr           wdata          be      exp_rdata      err
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'h00000055, 4'h1, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBE55, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hDEADBE55, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'h12345678, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,        4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h0000_0400, 32'hAAAAAAAA, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h0000_0002, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,        4'h0, 32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_03FC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h0000_03FC, 32'h11223344, 4'hA, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0,        4'h0, 32'h11FE330D, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0400, 32'h0,        4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0000_03FD, 32'h0,        4'h0, 32'h0,        1'b1});
        for (int i = 0; i < vecs.size(); i++) begin
            xfer(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                 vecs[i].exp_rdata, vecs[i].exp_err, 0, $sformatf("vec%0d", i));
        end

        // Backpressure with a stray store to 0x10 that must be ignored.
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBE55, 1'b0, 10, "bp");
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBE55, 1'b0, 0, "bp_after");

        // Reset mid-WAIT after a store has committed.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h0BADF00D;
        req_be[0]    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("rstw_in_wait_ready", 32'(req_ready[0]), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rstw_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rstw_ready", 32'(req_ready[0]), 32'd1);
        chk("rstw_rdata", rsp_rdata[0], 32'd0);
        chk("rstw_err", 32'(rsp_err[0]), 32'd0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid[0]) n++;
        end
        chk("rstw_no_ghost_rsp", 32'(n), 32'd0);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 0, "rstw_store_kept");

        // Boundary addresses and back-to-back throughput for each latency build.
        for (int d = 0; d < 3; d++) begin
            xfer(d, 1'b1, 32'h0,   32'hA0000000 + 32'(d), 4'hF, 32'h0, 1'b0, 0, $sformatf("tp%0d_st0", d));
            xfer(d, 1'b1, 32'h3FC, 32'h5F000000 + 32'(d), 4'hF, 32'h0, 1'b0, 0, $sformatf("tp%0d_st1", d));
            xfer(d, 1'b0, 32'h0,   32'h0, 4'h0, 32'hA0000000 + 32'(d), 1'b0, 0, $sformatf("tp%0d_ld0", d));
            t_a = last_t0;
            xfer(d, 1'b0, 32'h3FC, 32'h0, 4'h0, 32'h5F000000 + 32'(d), 1'b0, 0, $sformatf("tp%0d_ld1", d));
            chk($sformatf("tp%0d_interval", d), 32'(last_t0 - t_a), 32'(c_LAT[d] + 2));
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the core's data-memory request/response interface: accepts one load or store request at a time from the memory stage via a valid/ready handshake, performs it on a word-organised data array, and returns a response after a fixed, parameterised latency. It replaces a zero-latency combinational data memory, so the pipeline can be tested against realistic memory timing. It is the slave side of the same request/response interface whose master lives in the memory stage.

## Interface
- DATA_WIDTH, 32, data and address width; must be 32.
- DMEM_SZ_IN_KB, 1, array size; word count = DMEM_SZ_IN_KB*1024/4.
- LATENCY, 2, extra wait cycles between request acceptance and response valid; legal range 0..15.
- clk  in  1  clock, all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  DATA_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data.
- req_be  in  DATA_WIDTH/8  store byte enables; ignored for loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset forces IDLE, req_ready=1 (in IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Array contents are not reset.
- IDLE: req_ready=1. On req_valid && req_ready (acceptance edge):
  - Decode. err = (req_addr[1:0] != 0) || (req_addr[31:2] >= word count).
  - A store without err writes the bytes where req_be[i]=1 at this edge. req_be=0 is legal: no change, no error.
  - A load without err captures the array word into the rdata register at this edge. err or store sets the rdata register to 0.
  - Next state is WAIT with the counter loaded to LATENCY-1 if LATENCY>0. Otherwise next state is RESP.
- WAIT: req_ready=0. The counter decrements each cycle. The transition to RESP is taken on the edge where counter==0.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until the handshake. On rsp_valid && rsp_ready, next state is IDLE.
- req_valid while not in IDLE is ignored. The requester must hold its request until it is accepted.
- rst mid-operation (WAIT or RESP) discards the pending response. A store committed at its acceptance edge remains in the array.
- Only one request is outstanding at a time. Read-after-write ordering is therefore guaranteed.

## Timing
- Acceptance edge E0. rsp_valid is first high in the cycle after edge E0+LATENCY. For LATENCY=0, that is the cycle directly after E0.
- Response handshake at edge E1: rsp_valid falls and req_ready rises in the cycle after E1. There is no same-cycle response/accept overlap.
- Best-case throughput: one request per LATENCY+2 cycles.
- All outputs are registered or decoded from state only. There are no combinational paths from req_* or rsp_ready to any output.
- rsp_ready held low in RESP stalls indefinitely with no loss of data.

## Structure
- Package dmem_responder_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - struct dmem_req_t {we, addr, wdata, be};
  - struct dmem_rsp_t {rdata, err};
  - constant WORD_BYTES=4.
- The memory stage uses the same request and response types.
- Sub-module dmem_array: word-addressed storage with a per-byte write enable and a synchronous read, with no reset. The top level holds the FSM, the latency counter, error decode and the response registers.

## Test plan
- Reset: assert rst for 2 cycles mid-WAIT, then release. Required: rsp_valid=0, req_ready=1, rsp_rdata=0, rsp_err=0. No response ever appears for the discarded request.
- Store then load, LATENCY=2:
  - store 0xDEADBEEF to 0x10 with be=4'hF; rsp_valid rises 3 cycles after acceptance with err=0, rdata=0;
  - then load 0x10; required rdata=0xDEADBEEF.
- Partial store: with 0x10=0xDEADBEEF, store 0x00000055 with be=4'b0001. A load of 0x10 must return 0xDEADBE55. A store with be=0 must leave the word unchanged.
- Errors:
  - load 0x12 (misaligned) -> rsp_err=1, rdata=0;
  - store to 0x400 with DMEM_SZ_IN_KB=1 (out of range) -> rsp_err=1;
  - in both cases the array is unmodified (address 0x0 read back unchanged).
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP. rsp_valid, rdata and err must stay stable and req_ready must stay 0. A req_valid pulse during this time must not be accepted.
- LATENCY=0 and LATENCY=15 builds:
  - back-to-back loads with rsp_ready=1 complete every 2 and 17 cycles respectively;
  - the addresses 0x0 and 0x3FC return their preloaded values.
